// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder.
// Define MIPS_MC_BNE_EN to add BNE (op 000101) through the BRANCH state.
module mips_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t cur;
    state_t dec_next;

    logic       mreq_c;
    logic       mw_c;
    logic       irw_c;
    logic       rw_c;
    logic       ill_c;
    logic       pcw_c;
    logic       branch;
    logic       branchne;
    logic       valid_st;
    logic [1:0] aluop;
    logic [2:0] alu_c;

    assign state = cur;

    // Opcode dispatch out of DECODE; unknown opcodes fall back to FETCH
    always_comb begin
        dec_next = FETCH;
        ill_c    = 1'b0;
        case (op)
            OP_LW, OP_SW: dec_next = MEMADR;
            OP_R:         dec_next = EXECUTE;
            OP_BEQ:       dec_next = BRANCH;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:       dec_next = BRANCH;
`endif
            OP_ADDI:      dec_next = ADDIEXEC;
            OP_J:         dec_next = JUMP;
            default:      ill_c    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:    if (mem_ready) cur <= DECODE;
                DECODE:   cur <= dec_next;
                MEMADR:   cur <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:    if (mem_ready) cur <= MEMWB;
                MEMWB:    cur <= FETCH;
                MEMWR:    if (mem_ready) cur <= FETCH;
                EXECUTE:  cur <= ALUWB;
                ALUWB:    cur <= FETCH;
                BRANCH:   cur <= FETCH;
                ADDIEXEC: cur <= ADDIWB;
                ADDIWB:   cur <= FETCH;
                JUMP:     cur <= FETCH;
                default:  cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        mreq_c   = 1'b0;
        mw_c     = 1'b0;
        irw_c    = 1'b0;
        rw_c     = 1'b0;
        pcw_c    = 1'b0;
        branch   = 1'b0;
        branchne = 1'b0;
        valid_st = 1'b1;
        aluop    = 2'b00;
        iord     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        case (cur)
            FETCH: begin
                mreq_c  = 1'b1;
                alusrcb = 2'b01;
                irw_c   = mem_ready;
                pcw_c   = mem_ready;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                mreq_c = 1'b1;
                iord   = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                rw_c     = 1'b1;
            end
            MEMWR: begin
                mreq_c = 1'b1;
                iord   = 1'b1;
                mw_c   = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst = 1'b1;
                rw_c   = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
`ifdef MIPS_MC_BNE_EN
                branchne = (op == OP_BNE);
                branch   = (op != OP_BNE);
`else
                branch   = 1'b1;
`endif
            end
            ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB:  rw_c = 1'b1;
            JUMP: begin
                pcsrc = 2'b10;
                pcw_c = 1'b1;
            end
            default: valid_st = 1'b0;
        endcase
    end

    always_comb begin
        alu_c = 3'b010;
        case (aluop)
            2'b01: alu_c = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alu_c = 3'b110;
                    6'b100100: alu_c = 3'b000;
                    6'b100101: alu_c = 3'b001;
                    6'b101010: alu_c = 3'b111;
                    default:   alu_c = 3'b010;
                endcase
            end
            default: alu_c = 3'b010;
        endcase
    end

    assign alucontrol = valid_st ? alu_c : 3'b000;

    // Write/request strobes are gated by reset so nothing commits while held
    assign mem_req    = mreq_c & ~reset;
    assign memwrite   = mw_c & ~reset;
    assign irwrite    = irw_c & ~reset;
    assign regwrite   = rw_c & ~reset;
    assign illegal_op = ill_c & (cur == DECODE) & ~reset;
    assign pcen       = ~reset & (pcw_c | (branch & zero)
                                | (branchne & ~zero));

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 Parameters: none; the block is opcode-driven and independent of the datapath width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  instruction opcode, valid from the instruction register.
REQ-005 funct  input  6  R-type function field.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca  output  1 each  datapath selects and enables.
REQ-010 alusrcb, pcsrc  output  2 each  datapath mux selects.
REQ-011 alucontrol  output  3  ALU operation.
REQ-012 pcen  output  1  program counter enable-register write.
REQ-013 illegal_op  output  1  one-cycle pulse when an opcode is unsupported.
REQ-014 state  output  4  current state, for debug.

Function
REQ-015 Moore FSM; state encoding is FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-016 Every output not listed for a state SHALL be 0 in that state.
REQ-017 FETCH: mem_req=1, alusrcb=01.
- irwrite=mem_ready and pcwrite=mem_ready.
- Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-018 DECODE: alusrcb=11. Next state by op:
- 100011/101011 -> MEMADR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 -> ADDIEXEC
- 000010 -> JUMP
- any other op -> FETCH, with illegal_op=1 for this one cycle.
REQ-019 MEMADR: alusrca=1, alusrcb=10. Next state is MEMRD for op 100011, otherwise MEMWR.
REQ-020 MEMRD: mem_req=1, iord=1. Holds while mem_ready=0, then goes to MEMWB.
REQ-021 MEMWB: memtoreg=1, regwrite=1. Next state is FETCH.
REQ-022 MEMWR: mem_req=1, iord=1, memwrite=1.
- memwrite and the address selection stay stable until mem_ready=1.
- Then goes to FETCH.
REQ-023 EXECUTE: alusrca=1, aluop=10. Next state is ALUWB.
REQ-024 ALUWB: regdst=1, regwrite=1. Next state is FETCH.
REQ-025 BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1. Next state is FETCH.
REQ-026 ADDIEXEC: alusrca=1, alusrcb=10. Next state is ADDIWB.
REQ-027 ADDIWB: regwrite=1. Next state is FETCH.
REQ-028 JUMP: pcsrc=10, pcwrite=1. Next state is FETCH.
REQ-029 pcen = pcwrite | (branch & zero), combinational from state and zero.
REQ-030 alucontrol decode:
- aluop=00 -> 010 (add); aluop=01 -> 110 (subtract).
- aluop=10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
- Any other funct -> 010.
REQ-031 Unused state encodings 12-15 SHALL go to FETCH on the next clock with all outputs 0.
REQ-032 A mem_ready pulse outside FETCH, MEMRD and MEMWR SHALL be ignored.

Reset
REQ-033 While reset=1:
- state=FETCH, asynchronously.
- pcen, irwrite, regwrite, memwrite, mem_req and illegal_op are forced to 0.
REQ-034 Reset asserted mid-instruction SHALL abandon the instruction with no further write.
REQ-035 The first FETCH request SHALL issue on the first rising edge after reset deasserts.

Configuration
REQ-036 Macro MIPS_MC_BNE_EN controls BNE (op 000101) support.
- Defined: DECODE sends op 000101 to BRANCH with branchne=1, and pcen additionally ORs (branchne & ~zero).
- Undefined: op 000101 is illegal per REQ-018.

Verification
REQ-037 Reset release, lw (op=100011), mem_ready=1 every cycle -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in MEMWB.
REQ-038 sw, mem_ready=0 for 3 cycles in MEMWR -> memwrite=1 and iord=1 held for 4 cycles; one write completes; then FETCH.
REQ-039 beq, zero=1 -> pcen=1 in BRANCH with pcsrc=01; repeat with zero=0 -> pcen=0.
REQ-040 R-type, funct=101010 -> alucontrol=111 in EXECUTE; ALUWB has regdst=1 and regwrite=1.
REQ-041 op=111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH; op=000101 behaves the same without MIPS_MC_BNE_EN, and with it reaching BRANCH and zero=0 gives pcen=1.
REQ-042 reset asserted in MEMWR mid-wait -> memwrite=0 immediately, state=0.
